// File: rtl/cp0_ctrl_pkg.sv
// cp0_ctrl_pkg: CP0 register numbers, ExcCode values and Status/Cause field positions
package cp0_ctrl_pkg;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;
  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_WP     = 22;
  localparam int CA_IV     = 23;
  localparam int CA_BD     = 31;
  function automatic logic is_addr_exc(input logic [4:0] code);
    return code == EXC_ADEL || code == EXC_ADES;
  endfunction
endpackage

// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: MTC0/MFC0 bus plus MEM-stage exception/ERET commit signals
//   master (pipeline): drives we/waddr/wdata/raddr and exception/ERET, reads rdata
//   slave  (cp0_ctrl): the reverse
interface cp0_ctrl_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badva;
  logic        eret;
  modport master (output we, waddr, wdata, raddr, exc_valid, exc_code, exc_pc, exc_bd, exc_badva, eret,
                  input rdata);
  modport slave  (input we, waddr, wdata, raddr, exc_valid, exc_code, exc_pc, exc_bd, exc_badva, eret,
                  output rdata);
endinterface

// File: rtl/cp0_ctrl_timer.sv
// cp0_ctrl_timer: prescaled Count, Compare and sticky timer interrupt flag
//   count_we_i/compare_we_i load data_i; count_o/compare_o/timer_int_o are registered
module cp0_ctrl_timer #(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);
  localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d, compare_q, compare_d;
  logic          tint_q, tint_d, tick, inc_hit;
  always_comb begin
    tick      = presc_q == PW'(COUNT_DIV - 1);
    // a Count write beats the increment, so it also blocks the match
    inc_hit   = tick & ~count_we_i & (count_q + 32'd1 == compare_q);
    presc_d   = (count_we_i | tick) ? '0 : presc_q + 1'b1;
    count_d   = count_we_i ? data_i : tick ? count_q + 32'd1 : count_q;
    compare_d = compare_we_i ? data_i : compare_q;
    tint_d    = compare_we_i ? 1'b0 : inc_hit ? 1'b1 : tint_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      tint_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      tint_q    <= tint_d;
    end
  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = tint_q;
endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: CP0 system-control block (Status/Cause/EPC/BadVAddr, timer, interrupts, exceptions)
//   bus          : MTC0/MFC0 and exception/ERET commit (slave side)
//   int_i        : level hardware interrupts -> Cause.IP[2+k]
//   status_o/cause_o/epc_o : register views; int_req_o : masked pending interrupt;
//   timer_int_o  : sticky timer flag
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 1,
  parameter int          TIMER_IP   = 7,
  parameter logic [31:0] PRID_VAL   = 32'h0048_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cp0_ctrl_if.slave             bus,
  input  logic [NUM_HW_INT-1:0] int_i,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  int_req_o,
  output logic                  timer_int_o
);
  logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d, badva_q, badva_d;
  logic [31:0] count, compare;
  logic        int_req_q, int_req_d, timer_int;
  logic        wr_status, wr_cause, wr_epc, first_exc;
  logic [7:0]  ip_d;
  cp0_ctrl_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .count_we_i   (bus.we && bus.waddr == REG_COUNT),
    .compare_we_i (bus.we && bus.waddr == REG_COMPARE),
    .data_i       (bus.wdata),
    .count_o      (count),
    .compare_o    (compare),
    .timer_int_o  (timer_int)
  );
  always_comb begin
    wr_status = bus.we && bus.waddr == REG_STATUS;
    wr_cause  = bus.we && bus.waddr == REG_CAUSE;
    wr_epc    = bus.we && bus.waddr == REG_EPC;
    // nested exceptions keep the original EPC/BD
    first_exc = bus.exc_valid & ~status_q[ST_EXL];
    ip_d      = 8'h00;
    ip_d[1:0] = wr_cause ? bus.wdata[CA_IP_LO +: 2] : cause_q[CA_IP_LO +: 2];
    for (int k = 0; k < NUM_HW_INT; k++) ip_d[2+k] = int_i[k];
    ip_d[TIMER_IP] = ip_d[TIMER_IP] | timer_int;
    status_d  = wr_status ? bus.wdata : status_q;
    status_d[ST_EXL] = bus.exc_valid ? 1'b1 : bus.eret ? 1'b0 : status_d[ST_EXL];
    cause_d   = 32'h0;
    cause_d[CA_BD] = first_exc ? bus.exc_bd : cause_q[CA_BD];
    cause_d[CA_IV] = wr_cause ? bus.wdata[CA_IV] : cause_q[CA_IV];
    cause_d[CA_WP] = wr_cause ? bus.wdata[CA_WP] : cause_q[CA_WP];
    cause_d[CA_IP_LO +: 8]  = ip_d;
    cause_d[CA_EXC_LO +: 5] = bus.exc_valid ? bus.exc_code : cause_q[CA_EXC_LO +: 5];
    epc_d     = first_exc ? (bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc) : wr_epc ? bus.wdata : epc_q;
    badva_d   = (bus.exc_valid && is_addr_exc(bus.exc_code)) ? bus.exc_badva : badva_q;
    int_req_d = status_q[ST_IE] & ~status_q[ST_EXL] & |(cause_q[CA_IP_LO +: 8] & status_q[ST_IM_LO +: 8]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      status_q  <= STATUS_RST;
      cause_q   <= '0;
      epc_q     <= '0;
      badva_q   <= '0;
      int_req_q <= 1'b0;
    end else begin
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      badva_q   <= badva_d;
      int_req_q <= int_req_d;
    end
  always_comb
    case (bus.raddr)
      REG_BADVADDR: bus.rdata = badva_q;
      REG_COUNT:    bus.rdata = count;
      REG_COMPARE:  bus.rdata = compare;
      REG_STATUS:   bus.rdata = status_q;
      REG_CAUSE:    bus.rdata = cause_q;
      REG_EPC:      bus.rdata = epc_q;
      REG_PRID:     bus.rdata = PRID_VAL;
      REG_CONFIG:   bus.rdata = CONFIG_VAL;
      default:      bus.rdata = 32'h0;
    endcase
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign int_req_o   = int_req_q;
  assign timer_int_o = timer_int;
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed vector table plus hand sequences for timer, collisions and async reset
module tb_cp0_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  int_i = '0;
  logic [31:0] status_o, cause_o, epc_o, d;
  logic        int_req_o, timer_int_o;
  int          n_chk = 0;
  int          n_fail = 0;
  cp0_ctrl_if bus ();
  cp0_ctrl #(.COUNT_DIV(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .int_i       (int_i),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .epc_o       (epc_o),
    .int_req_o   (int_req_o),
    .timer_int_o (timer_int_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] badva;
    logic        eret;
    logic [5:0]  irq;
    logic [2:0]  src;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 25;
  vec_t v [NV];
  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic exc, input logic [4:0] code, input logic [31:0] pc,
                              input logic bd, input logic [31:0] bva, input logic eret,
                              input logic [5:0] irq, input logic [2:0] src, input logic [4:0] ra,
                              input logic [31:0] exp);
    vec_t r;
    r.we = we; r.waddr = wa; r.wdata = wd; r.exc = exc; r.code = code; r.pc = pc; r.bd = bd;
    r.badva = bva; r.eret = eret; r.irq = irq; r.src = src; r.raddr = ra; r.exp = exp;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.we = 1'b0;
    bus.exc_valid = 1'b0;
    bus.eret = 1'b0;
  endtask
  task automatic mtc0(input logic [4:0] a, input logic [31:0] dat);
    bus.we = 1'b1;
    bus.waddr = a;
    bus.wdata = dat;
    tick();
    bus.we = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a, output logic [31:0] dat);
    bus.raddr = a;
    #1;
    dat = bus.rdata;
  endtask
  initial begin
    int n;
    logic [31:0] got;
    idle();
    bus.waddr = '0; bus.wdata = '0; bus.raddr = '0; bus.exc_code = '0;
    bus.exc_pc = '0; bus.exc_bd = 1'b0; bus.exc_badva = '0;
    // src: 0 data_o@raddr, 1 status_o, 2 cause_o, 3 epc_o, 4 int_req_o
    v[0]  = mk(1, 12, 32'h1000_0401, 0, 0, 0,      0, 0,       0, 6'h00, 1, 0,  32'h1000_0401);
    v[1]  = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h01, 2, 0,  32'h0000_0400);
    v[2]  = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h01, 4, 0,  32'h1);
    v[3]  = mk(1, 12, 32'h1000_0400, 0, 0, 0,      0, 0,       0, 6'h01, 1, 0,  32'h1000_0400);
    v[4]  = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h01, 4, 0,  32'h0);
    v[5]  = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h00, 0, 13, 32'h0);
    v[6]  = mk(0, 0,  0,             1, 8, 32'h100, 1, 0,      0, 6'h00, 3, 0,  32'h0000_00FC);
    v[7]  = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h00, 2, 0,  32'h8000_0020);
    v[8]  = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h00, 1, 0,  32'h1000_0402);
    v[9]  = mk(0, 0,  0,             1, 12, 32'h200, 0, 0,     0, 6'h00, 3, 0,  32'h0000_00FC);
    v[10] = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h00, 2, 0,  32'h8000_0030);
    v[11] = mk(0, 0,  0,             1, 4, 32'h300, 0, 32'h1003, 0, 6'h00, 0, 8, 32'h0000_1003);
    v[12] = mk(0, 0,  0,             0, 0, 0,      0, 0,       1, 6'h00, 1, 0,  32'h1000_0400);
    v[13] = mk(0, 0,  0,             1, 5, 32'h400, 0, 32'h2000, 1, 6'h00, 1, 0, 32'h1000_0402);
    v[14] = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h00, 0, 14, 32'h0000_0400);
    v[15] = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h00, 2, 0,  32'h0000_0014);
    v[16] = mk(0, 0,  0,             0, 0, 0,      0, 0,       1, 6'h00, 1, 0,  32'h1000_0400);
    v[17] = mk(1, 14, 32'h55,        1, 0, 32'h80, 0, 0,       0, 6'h00, 3, 0,  32'h0000_0080);
    v[18] = mk(0, 0,  0,             0, 0, 0,      0, 0,       1, 6'h00, 1, 0,  32'h1000_0400);
    v[19] = mk(1, 14, 32'h55,        0, 0, 0,      0, 0,       0, 6'h00, 0, 14, 32'h0000_0055);
    v[20] = mk(1, 13, 32'hFFFF_FFFF, 0, 0, 0,      0, 0,       0, 6'h00, 2, 0,  32'h00C0_0300);
    v[21] = mk(1, 12, 32'h1000_0301, 0, 0, 0,      0, 0,       0, 6'h00, 4, 0,  32'h0);
    v[22] = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h00, 4, 0,  32'h1);
    v[23] = mk(0, 0,  0,             0, 0, 0,      0, 0,       0, 6'h00, 0, 3,  32'h0);
    v[24] = mk(1, 11, 32'h1234,      0, 0, 0,      0, 0,       0, 6'h00, 0, 11, 32'h0000_1234);
    #12;
    chk("rst_status", status_o, 32'h1000_0000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_flags", {30'b0, int_req_o, timer_int_o}, 32'h0);
    rd(15, d); chk("prid", d, 32'h0048_0102);
    rd(16, d); chk("config", d, 32'h0000_8000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // timer: Count<=0 then Compare<=5; with COUNT_DIV=2 Count hits 5 ten edges after the Count write
    mtc0(9, 32'h0);
    mtc0(11, 32'h5);
    n = 0;
    while (!timer_int_o && n < 40) begin
      tick();
      n++;
    end
    chk("timer_edges", n, 9);
    rd(9, d); chk("timer_count", d, 32'h5);
    tick();
    chk("timer_sticky", {31'b0, timer_int_o}, 32'h1);
    chk("cause_ip7", {31'b0, cause_o[15]}, 32'h1);
    mtc0(11, 32'd20);
    chk("timer_clr", {31'b0, timer_int_o}, 32'h0);
    // Count write on a tick cycle: written value wins, prescaler restarts
    mtc0(9, 32'h100);
    tick();
    mtc0(9, 32'h200);
    rd(9, d); chk("count_wr_tick", d, 32'h200);
    tick();
    tick();
    rd(9, d); chk("count_after", d, 32'h201);
    // Compare=0 fires on wrap
    mtc0(11, 32'h0);
    mtc0(9, 32'hFFFF_FFFF);
    tick();
    chk("wrap_pre", {31'b0, timer_int_o}, 32'h0);
    tick();
    rd(9, d); chk("wrap_count", d, 32'h0);
    chk("wrap_fire", {31'b0, timer_int_o}, 32'h1);
    mtc0(11, 32'hFFFF_0000);
    for (int i = 0; i < NV; i++) begin
      bus.we = v[i].we; bus.waddr = v[i].waddr; bus.wdata = v[i].wdata;
      bus.exc_valid = v[i].exc; bus.exc_code = v[i].code; bus.exc_pc = v[i].pc;
      bus.exc_bd = v[i].bd; bus.exc_badva = v[i].badva; bus.eret = v[i].eret;
      int_i = v[i].irq;
      tick();
      idle();
      bus.raddr = v[i].raddr;
      #1;
      got = v[i].src == 0 ? bus.rdata : v[i].src == 1 ? status_o : v[i].src == 2 ? cause_o :
            v[i].src == 3 ? epc_o : {31'b0, int_req_o};
      chk($sformatf("vec%0d", i), got, v[i].exp);
    end
    // async reset between edges, with a pending MTC0 that must be discarded
    bus.we = 1'b1; bus.waddr = 12; bus.wdata = 32'hFFFF_FFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", status_o, 32'h1000_0000);
    chk("mid_rst_epc", epc_o, 32'h0);
    chk("mid_rst_int_req", {31'b0, int_req_o}, 32'h0);
    rd(9, d); chk("mid_rst_count", d, 32'h0);
    tick();
    chk("rst_hold_status", status_o, 32'h1000_0000);
    rd(31, d); chk("unmapped", d, 32'h0);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
